// File: rtl/led_seq_pkg.sv
// Shared types and constants for the LED frame sequencer and its benches.
package led_seq_pkg;

    localparam int unsigned PWM_BITS = 8;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StSclkLo,
        StSclkHi,
        StLatch,
        StAdvance
    } seq_state_e;

    typedef enum logic {
        WordLed    = 1'b0,
        WordBright = 1'b1
    } word_type_e;

    // Clocks from one LOAD to the next while running continuously.
    function automatic int unsigned word_period(input int unsigned width,
                                                input int unsigned sclk_half,
                                                input int unsigned latch_cycles);
        return 1 + 2 * sclk_half * width + latch_cycles + 1;
    endfunction

endpackage

// File: rtl/sclk_phase_timer.sv
// Down-counter timing one sclk half-period or the latch pulse; reloaded on each phase entry.
module sclk_phase_timer #(
    parameter int unsigned CntW = 2
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            load_i,
    input  logic [CntW-1:0] load_val_i,
    output logic            done_o,
    output logic            done_next_o
);
    logic [CntW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i - CntW'(1);
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CntW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done_o      = (cnt_q == '0);
    // Lets the caller register a pulse that lands on the last clk of the phase.
    assign done_next_o = (cnt_d == '0);

endmodule

// File: rtl/led_frame_sequencer.sv
// Timing master for a bank of color component drivers: sweeps the PWM step, serialises one
// word per step onto sclk/latch, and splices in a brightness word at frame start on request.
module led_frame_sequencer
    import led_seq_pkg::*;
#(
    parameter int unsigned WIDTH        = 16,
    parameter int unsigned SCLK_HALF    = 2,
    parameter int unsigned LATCH_CYCLES = 2
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                enable_i,
    input  logic                brightness_req_i,
    output logic [PWM_BITS-1:0] pwm_time_o,
    output logic                load_led_vals_o,
    output logic                load_brightness_o,
    output logic                shift_o,
    output logic                sclk_o,
    output logic                latch_o,
    output logic                config_mode_o,
    output logic                oe_n_o,
    output logic                frame_start_o,
    output logic                busy_o
);
    localparam int unsigned MaxReload = (SCLK_HALF > LATCH_CYCLES) ? SCLK_HALF : LATCH_CYCLES;
    localparam int unsigned TimerW    = $clog2(MaxReload + 1);
    localparam int unsigned BitW      = $clog2(WIDTH + 1);

    seq_state_e          state_q, state_d;
    word_type_e          word_q, word_d;
    logic [PWM_BITS-1:0] pwm_q, pwm_d;
    logic [BitW-1:0]     bit_cnt_q, bit_cnt_d;
    logic                pending_q, pending_d;
    logic                config_q, config_d;
    logic                oe_n_q, oe_n_d;
    logic                load_led_q, load_led_d;
    logic                load_bri_q, load_bri_d;
    logic                shift_q, shift_d;
    logic                sclk_q, sclk_d;
    logic                latch_q, latch_d;
    logic                frame_q, frame_d;

    logic                timer_load, timer_done, timer_done_next;
    logic [TimerW-1:0]   timer_val;

    always_comb begin
        state_d   = state_q;
        word_d    = word_q;
        pwm_d     = pwm_q;
        bit_cnt_d = bit_cnt_q;
        pending_d = pending_q;
        config_d  = config_q;
        oe_n_d    = oe_n_q;
        frame_d   = 1'b0;
        unique case (state_q)
            StIdle:   if (enable_i) state_d = StLoad;
            StLoad:   state_d = StSclkLo;
            StSclkLo: if (timer_done) state_d = StSclkHi;
            StSclkHi: begin
                if (timer_done) begin
                    bit_cnt_d = bit_cnt_q + BitW'(1);
                    state_d   = (bit_cnt_d == BitW'(WIDTH)) ? StLatch : StSclkLo;
                end
            end
            StLatch: begin
                if (timer_done) begin
                    state_d = StAdvance;
                    // Bookkeeping lands on ADVANCE entry so config_mode spans the latch.
                    if (word_q == WordBright) begin
                        pending_d = 1'b0;
                        config_d  = 1'b0;
                    end else begin
                        pwm_d   = pwm_q + PWM_BITS'(1);
                        frame_d = (pwm_q == '1);
                    end
                end
            end
            StAdvance: state_d = enable_i ? StLoad : StIdle;
            default:   state_d = StIdle;
        endcase

        if (state_d == StLoad) begin
            word_d    = (pending_q && (pwm_q == '0)) ? WordBright : WordLed;
            bit_cnt_d = '0;
            config_d  = (word_d == WordBright);
        end
        if (state_d == StLatch) oe_n_d = 1'b0;
        if (state_d == StIdle) oe_n_d = 1'b1;
        if (brightness_req_i) pending_d = 1'b1;
    end

    assign load_led_d = (state_d == StLoad) && (word_d == WordLed);
    assign load_bri_d = (state_d == StLoad) && (word_d == WordBright);
    assign sclk_d     = (state_d == StSclkHi);
    assign latch_d    = (state_d == StLatch);
    assign shift_d    = (state_d == StSclkHi) && timer_done_next;

    assign timer_load = (state_d != state_q) &&
                        ((state_d == StSclkLo) || (state_d == StSclkHi) || (state_d == StLatch));
    assign timer_val  = (state_d == StLatch) ? TimerW'(LATCH_CYCLES) : TimerW'(SCLK_HALF);

    sclk_phase_timer #(
        .CntW(TimerW)
    ) u_phase_timer (
        .clk        (clk),
        .reset_n    (reset_n),
        .load_i     (timer_load),
        .load_val_i (timer_val),
        .done_o     (timer_done),
        .done_next_o(timer_done_next)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= StIdle;
            word_q     <= WordLed;
            pwm_q      <= '0;
            bit_cnt_q  <= '0;
            pending_q  <= 1'b0;
            config_q   <= 1'b0;
            oe_n_q     <= 1'b1;
            load_led_q <= 1'b0;
            load_bri_q <= 1'b0;
            shift_q    <= 1'b0;
            sclk_q     <= 1'b0;
            latch_q    <= 1'b0;
            frame_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            word_q     <= word_d;
            pwm_q      <= pwm_d;
            bit_cnt_q  <= bit_cnt_d;
            pending_q  <= pending_d;
            config_q   <= config_d;
            oe_n_q     <= oe_n_d;
            load_led_q <= load_led_d;
            load_bri_q <= load_bri_d;
            shift_q    <= shift_d;
            sclk_q     <= sclk_d;
            latch_q    <= latch_d;
            frame_q    <= frame_d;
        end
    end

    assign pwm_time_o        = pwm_q;
    assign load_led_vals_o   = load_led_q;
    assign load_brightness_o = load_bri_q;
    assign shift_o           = shift_q;
    assign sclk_o            = sclk_q;
    assign latch_o           = latch_q;
    assign config_mode_o     = config_q;
    assign oe_n_o            = oe_n_q;
    assign frame_start_o     = frame_q;
    assign busy_o            = (state_q != StIdle);

endmodule

// File: tb/tb_led_frame_sequencer.sv
// Scoreboarded bench: stimulus queues the expected word sequence, monitors check each word.
module tb_led_frame_sequencer;

    logic       clk = 1'b0;
    logic       reset_n, enable, brightness_req;
    logic [7:0] pwm_time;
    logic       load_led, load_bri, shift, sclk, latch, config_mode, oe_n, frame_start, busy;
    logic [7:0] f_pwm_time;
    logic       f_load_led, f_load_bri, f_shift, f_sclk, f_latch, f_config_mode, f_oe_n;
    logic       f_frame_start, f_busy;

    always #5 clk = ~clk;

    led_frame_sequencer u_dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .enable_i         (enable),
        .brightness_req_i (brightness_req),
        .pwm_time_o       (pwm_time),
        .load_led_vals_o  (load_led),
        .load_brightness_o(load_bri),
        .shift_o          (shift),
        .sclk_o           (sclk),
        .latch_o          (latch),
        .config_mode_o    (config_mode),
        .oe_n_o           (oe_n),
        .frame_start_o    (frame_start),
        .busy_o           (busy)
    );

    led_frame_sequencer #(
        .SCLK_HALF   (1),
        .LATCH_CYCLES(1)
    ) u_dut_fast (
        .clk              (clk),
        .reset_n          (reset_n),
        .enable_i         (enable),
        .brightness_req_i (brightness_req),
        .pwm_time_o       (f_pwm_time),
        .load_led_vals_o  (f_load_led),
        .load_brightness_o(f_load_bri),
        .shift_o          (f_shift),
        .sclk_o           (f_sclk),
        .latch_o          (f_latch),
        .config_mode_o    (f_config_mode),
        .oe_n_o           (f_oe_n),
        .frame_start_o    (f_frame_start),
        .busy_o           (f_busy)
    );

    typedef struct packed {
        logic       bright;
        logic [7:0] pwm;
    } exp_t;

    exp_t        exp_q[$];
    int unsigned checks = 0;
    int unsigned passes = 0;

    task automatic chk(input string name, input longint act, input longint want);
        checks++;
        if (act == want) passes++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, want);
    endtask

    task automatic push_exp(input logic b, input logic [7:0] p);
        exp_t e;
        e.bright = b;
        e.pwm    = p;
        exp_q.push_back(e);
    endtask

    task automatic wait_load(input logic b, input logic [7:0] p, input int limit,
                             input string name);
        int n = 0;
        while (!(((b ? load_bri : load_led) == 1'b1) && pwm_time == p) && n < limit) begin
            @(negedge clk);
            n++;
        end
        chk(name, (n < limit), 1);
    endtask

    // Main-DUT monitor: scoreboard on loads, per-word timing checks on latch fall.
    int unsigned cyc = 0, load_cyc = 0, prev_load_cyc = 0;
    logic        in_word = 0, word_bright = 0, have_prev_load = 0, saw_idle = 0;
    logic        prev_sclk = 0, prev_latch = 0, pwm_valid = 0;
    logic [7:0]  prev_pwm = 0, nxt_pwm;
    int          shift_cnt, shift_hi_cnt, sclk_rise, latch_cnt, latch_first, first_shift, cfg_cnt;
    int          frame_cnt = 0;
    exp_t        got;

    always @(negedge clk) begin
        cyc++;
        if (!reset_n) begin
            in_word = 0; have_prev_load = 0; pwm_valid = 0; prev_sclk = 0; prev_latch = 0;
        end else begin
            if (!busy) saw_idle = 1;
            if (frame_start) frame_cnt++;
            if (pwm_valid && pwm_time != prev_pwm) begin
                nxt_pwm = prev_pwm + 8'd1;
                chk("pwm_step", pwm_time, nxt_pwm);
                chk("pwm_step_offset", cyc - load_cyc, 67);
                chk("frame_start_on_wrap", frame_start, (pwm_time == 8'd0));
            end
            prev_pwm  = pwm_time;
            pwm_valid = 1;
            if (load_led || load_bri) begin
                chk("load_exclusive", (load_led && load_bri), 0);
                chk("sb_nonempty", (exp_q.size() != 0), 1);
                if (exp_q.size() != 0) begin
                    got = exp_q.pop_front();
                    chk("sb_word_type", load_bri, got.bright);
                    chk("sb_pwm_time", pwm_time, got.pwm);
                end
                if (have_prev_load && !saw_idle) chk("word_period", cyc - prev_load_cyc, 68);
                if (load_bri) chk("config_with_load", config_mode, 1);
                have_prev_load = 1; prev_load_cyc = cyc; saw_idle = 0;
                in_word = 1; load_cyc = cyc; word_bright = load_bri;
                shift_cnt = 0; shift_hi_cnt = 0; sclk_rise = 0; latch_cnt = 0; cfg_cnt = 0;
                latch_first = -1; first_shift = -1;
            end
            if (in_word) begin
                if (config_mode) cfg_cnt++;
                if (shift) begin
                    shift_cnt++;
                    if (sclk) shift_hi_cnt++;
                    if (first_shift < 0) first_shift = cyc - load_cyc;
                end
                if (sclk && !prev_sclk) sclk_rise++;
                if (latch) begin
                    latch_cnt++;
                    if (latch_first < 0) latch_first = cyc - load_cyc;
                end
                if (!latch && prev_latch) begin
                    chk("shifts_per_word", shift_cnt, 16);
                    chk("shift_on_sclk_hi", shift_hi_cnt, 16);
                    chk("sclk_rises", sclk_rise, 16);
                    chk("first_shift_ofs", first_shift, 4);
                    chk("latch_len", latch_cnt, 2);
                    chk("latch_ofs", latch_first, 65);
                    chk("config_span", cfg_cnt, word_bright ? 67 : 0);
                    chk("oe_n_running", oe_n, 0);
                    in_word = 0;
                end
            end
            prev_sclk  = sclk;
            prev_latch = latch;
        end
    end

    // Fast-timing DUT: first few words after the initial reset only.
    int   d1_loads = 0, d1_hi = 0, d1_rise = 0;
    int unsigned d1_last = 0;
    logic d1_done = 0, d1_prev_sclk = 0;

    always @(negedge clk) begin
        if (!reset_n) begin
            d1_loads = 0; d1_prev_sclk = 0;
        end else if (!d1_done) begin
            if (f_load_led || f_load_bri) begin
                if (d1_loads > 0) begin
                    chk("fast_word_period", cyc - d1_last, 35);
                    chk("fast_sclk_hi_clks", d1_hi, 16);
                    chk("fast_sclk_rises", d1_rise, 16);
                end
                d1_loads++;
                d1_last = cyc; d1_hi = 0; d1_rise = 0;
                if (d1_loads == 5) d1_done = 1;
            end
            if (f_sclk) d1_hi++;
            if (f_sclk && !d1_prev_sclk) d1_rise++;
            d1_prev_sclk = f_sclk;
        end
    end

    initial begin
        int n, k;
        reset_n = 1'b0; enable = 1'b1; brightness_req = 1'b0;
        for (int p = 0; p < 256; p++) push_exp(1'b0, 8'(p));
        push_exp(1'b1, 8'd0);
        for (int p = 0; p <= 42; p++) push_exp(1'b0, 8'(p));
        push_exp(1'b0, 8'd0);
        push_exp(1'b0, 8'd1);

        repeat (3) @(negedge clk);
        chk("rst_pwm_time", pwm_time, 0);
        chk("rst_load_led", load_led, 0);
        chk("rst_load_bri", load_bri, 0);
        chk("rst_shift", shift, 0);
        chk("rst_sclk", sclk, 0);
        chk("rst_latch", latch, 0);
        chk("rst_config", config_mode, 0);
        chk("rst_oe_n", oe_n, 1);
        chk("rst_frame_start", frame_start, 0);
        chk("rst_busy", busy, 0);
        reset_n = 1'b1;

        n = 0;
        while (pwm_time != 8'd100 && n < 20000) begin @(negedge clk); n++; end
        chk("reach_pwm100", pwm_time, 100);
        brightness_req = 1'b1;
        @(negedge clk);
        brightness_req = 1'b0;

        wait_load(1'b1, 8'd0, 20000, "reach_bright_word");
        wait_load(1'b0, 8'd40, 5000, "reach_pwm40");
        n = 0; k = 0;
        while (k < 7 && n < 100) begin
            @(negedge clk);
            n++;
            if (shift) k++;
        end
        chk("seven_shifts", k, 7);
        enable = 1'b0;
        n = 0;
        while (busy && n < 200) begin @(negedge clk); n++; end
        chk("idle_after_drop", busy, 0);
        chk("pwm_after_drop", pwm_time, 41);
        chk("oe_n_after_drop", oe_n, 1);
        n = 0;
        repeat (10) begin
            @(negedge clk);
            if (busy || load_led) n++;
        end
        chk("stays_idle", n, 0);
        chk("pwm_held", pwm_time, 41);
        enable = 1'b1;

        wait_load(1'b0, 8'd42, 400, "reach_pwm42");
        n = 0;
        while (!shift && n < 20) begin @(negedge clk); n++; end
        chk("shift_before_reset", shift, 1);
        #2 reset_n = 1'b0;
        #1;
        chk("abort_sclk", sclk, 0);
        chk("abort_shift", shift, 0);
        chk("abort_latch", latch, 0);
        chk("abort_pwm_time", pwm_time, 0);
        chk("abort_busy", busy, 0);
        chk("abort_oe_n", oe_n, 1);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;

        n = 0;
        while (exp_q.size() != 0 && n < 400) begin @(negedge clk); n++; end
        chk("sb_drained", exp_q.size(), 0);
        chk("frame_start_count", frame_cnt, 1);
        chk("fast_words_checked", d1_done, 1);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: timeout reached, expected run to finish");
        $fatal(1);
    end

endmodule
